ftdi_rx_packer: RTL

Receive-side datapath stage directly downstream of the FTDI controller. It samples the FTDI data bus on each `q_asserted` strobe and packs consecutive bytes little-endian into words. Words are buffered in a small first-word-fall-through FIFO and presented to the SDRAM stream writer over a valid/ready handshake. It also feeds back a hold signal so that the integration logic can gate `rxf` before the FIFO overruns.

---
 rtl/ftdi_rx_packer.sv | 96 +++++++++
 1 files changed

// File: rtl/ftdi_rx_packer.sv
// Packs FTDI receive bytes little-endian into words and buffers them in a small
// first-word-fall-through FIFO with a valid/ready output and an rxf hold signal.
module ftdi_rx_packer #(
    parameter int WORD_BYTES = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ftdi_d,
    input  logic                    q_asserted,
    input  logic                    flush,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    rx_hold,
    output logic                    overflow,
    output logic [15:0]             word_count
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(WORD_BYTES);

    // byte_idx is the packer state: 0 = IDLE, anything else = FILLING
    logic [IW-1:0] byte_idx;
    logic [W-1:0]  pack_q;
    logic [W-1:0]  pack_nxt;
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          last_byte;
    logic          push;
    logic          pop;
    logic          accept;

    always_comb begin
        pack_nxt = pack_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (q_asserted && (byte_idx == IW'(i))) begin
                pack_nxt[8*i +: 8] = ftdi_d;
            end
        end
        last_byte = q_asserted && (byte_idx == IW'(WORD_BYTES - 1));
        // A flush alongside a completing strobe collapses into the normal push.
        push      = last_byte || (flush && (q_asserted || (byte_idx != '0)));
        pop       = out_valid && out_ready;
        accept    = push && ((count != (AW+1)'(FIFO_DEPTH)) || pop);
        count_nxt = count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            pack_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_hold    <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (push) begin
                byte_idx <= '0;
                pack_q   <= '0;
            end else if (q_asserted) begin
                byte_idx <= byte_idx + 1'b1;
                pack_q   <= pack_nxt;
            end
            if (accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= word_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            // One-cycle feedback delay plus one in-flight byte needs a spare entry.
            rx_hold <= (count_nxt >= (AW+1)'(FIFO_DEPTH - 1));
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= pack_nxt;
        end
    end

endmodule
